// File: rtl/width_serializer_pkg.sv
// width_serializer_pkg: shared definitions for the wide/narrow width converters.
// Holds the FSM state encodings, the AMOUNT/CNT_WIDTH derivations and the ratio check,
// so the narrow-to-wide deserializer can reuse them.
package width_serializer_pkg;

  typedef enum logic [0:0] {
    WS_IDLE  = 1'b0,
    WS_SHIFT = 1'b1
  } ws_state_e;

  // Number of OWIDTH fragments in one IWIDTH word.
  function automatic int ws_amount(input int iwidth, input int owidth);
    return (owidth > 0) ? (iwidth / owidth) : 0;
  endfunction

  // Counter width for AMOUNT fragments; never narrower than one bit.
  function automatic int ws_cnt_width(input int amount);
    return (amount < 2) ? 1 : $clog2(amount);
  endfunction

  // Legal geometry: exact multiple and at least two fragments per word.
  function automatic bit ws_ratio_ok(input int iwidth, input int owidth);
    return (owidth > 0) && ((iwidth % owidth) == 0) && ((iwidth / owidth) >= 2);
  endfunction

endpackage

// File: rtl/width_serializer_frag_select.sv
// width_serializer_frag_select: combinational AMOUNT:1 fragment mux.
// Emission index cnt is remapped to a slice index (reversed when MSB_FIRST=1),
// then the matching OWIDTH slice of the held word is selected.
module width_serializer_frag_select
  import width_serializer_pkg::*;
#(
  parameter int IWIDTH    = 288,
  parameter int OWIDTH    = 36,
  parameter int MSB_FIRST = 0,
  localparam int AMOUNT    = ws_amount(IWIDTH, OWIDTH),
  localparam int CNT_WIDTH = ws_cnt_width(AMOUNT)
) (
  input  logic [IWIDTH-1:0]    word,
  input  logic [CNT_WIDTH-1:0] cnt,
  output logic [OWIDTH-1:0]    frag
);

  logic [CNT_WIDTH-1:0] slot;

  // Map emission order onto slice position.
  always_comb begin
    slot = cnt;
    if (MSB_FIRST != 0) begin
      slot = CNT_WIDTH'(AMOUNT - 1) - cnt;
    end
  end

  // Decoded mux; counter codes beyond AMOUNT-1 select zero.
  always_comb begin
    frag = '0;
    for (int i = 0; i < AMOUNT; i++) begin
      if (slot == CNT_WIDTH'(i)) begin
        frag = word[i*OWIDTH +: OWIDTH];
      end
    end
  end

endmodule

// File: rtl/width_serializer.sv
// width_serializer: handshaked wide-to-narrow serializer.
// One IWIDTH word accepted on in_valid/in_ready is emitted as IWIDTH/OWIDTH fragments
// on out_valid/out_ready, with out_last on the final fragment and out_idx giving the
// emission index. The last-fragment handshake may accept the next word in the same
// cycle, giving one fragment per cycle with no bubbles.
// Optional feature macro: WIDTH_SERIALIZER_KEEP_EN adds in_frags, a per-word count of
// valid fragments (0 means all); fragments past the count are skipped.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   WS_IDLE  | holding register empty, in_ready high, out_valid low
//   WS_SHIFT | word held, fragment cnt presented on the output
module width_serializer
  import width_serializer_pkg::*;
#(
  parameter int IWIDTH    = 288,
  parameter int OWIDTH    = 36,
  parameter int MSB_FIRST = 0,
  localparam int AMOUNT    = ws_amount(IWIDTH, OWIDTH),
  localparam int CNT_WIDTH = ws_cnt_width(AMOUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IWIDTH-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OWIDTH-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] out_idx
`ifdef WIDTH_SERIALIZER_KEEP_EN
  ,
  input  logic [CNT_WIDTH:0]   in_frags
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(AMOUNT - 1);

  if (!ws_ratio_ok(IWIDTH, OWIDTH)) begin : g_bad_ratio
    $error("width_serializer: IWIDTH=%0d must be a multiple of OWIDTH=%0d with at least 2 fragments",
           IWIDTH, OWIDTH);
  end

  ws_state_e            state_q, state_d;
  logic [IWIDTH-1:0]    hold_q, hold_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] last_idx;
  logic                 last_frag;
  logic                 out_fire;
  logic                 word_done;
  logic                 in_fire;

`ifdef WIDTH_SERIALIZER_KEEP_EN
  localparam logic [CNT_WIDTH:0] FRAGS_MAX = (CNT_WIDTH + 1)'(AMOUNT);

  logic [CNT_WIDTH-1:0] last_idx_q, last_idx_d;

  // Latch the final emission index with the word; 0 or out-of-range counts mean a full word.
  always_comb begin
    last_idx_d = last_idx_q;
    if (in_fire) begin
      if ((in_frags == '0) || (in_frags > FRAGS_MAX)) begin
        last_idx_d = CNT_LAST;
      end else begin
        last_idx_d = CNT_WIDTH'(in_frags - 1'b1);
      end
    end
  end

  // Per-word fragment-count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx_q <= CNT_LAST;
    end else begin
      last_idx_q <= last_idx_d;
    end
  end

  assign last_idx = last_idx_q;
`else
  assign last_idx = CNT_LAST;
`endif

  // Handshake decode, FSM next state, counter and holding-register update.
  always_comb begin
    out_valid = (state_q == WS_SHIFT);
    last_frag = (cnt_q == last_idx);
    out_last  = out_valid & last_frag;
    out_fire  = out_valid & out_ready;
    word_done = out_fire & last_frag;
    in_ready  = ~out_valid | word_done;
    in_fire   = in_valid & in_ready;

    state_d = state_q;
    case (state_q)
      WS_IDLE:  if (in_fire) state_d = WS_SHIFT;
      WS_SHIFT: if (word_done && !in_fire) state_d = WS_IDLE;
      default:  state_d = WS_IDLE;
    endcase

    hold_d = hold_q;
    if (in_fire) begin
      hold_d = in_data;
    end

    // A new word or the end of the current one both restart emission at index 0.
    cnt_d = cnt_q;
    if (in_fire || word_done) begin
      cnt_d = '0;
    end else if (out_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counter and holding register; reset drops any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WS_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_idx = cnt_q;

  // Fragments come only from registered state, so they are stable under backpressure.
  width_serializer_frag_select #(
    .IWIDTH    (IWIDTH),
    .OWIDTH    (OWIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_frag_select (
    .word (hold_q),
    .cnt  (cnt_q),
    .frag (out_data)
  );

endmodule

// File: tb/tb_width_serializer.sv
`timescale 1ns/1ps
module tb_width_serializer;

  localparam int IW  = 32;
  localparam int OW  = 8;
  localparam int AMT = IW / OW;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          out_ready;

  logic          in_ready_l, out_valid_l, out_last_l;
  logic [OW-1:0] out_data_l;
  logic [CW-1:0] out_idx_l;
  logic          in_ready_m, out_valid_m, out_last_m;
  logic [OW-1:0] out_data_m;
  logic [CW-1:0] out_idx_m;
`ifdef WIDTH_SERIALIZER_KEEP_EN
  logic [CW:0]   in_frags;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OW-1:0] dl;
    logic [OW-1:0] dm;
    int            idx;
    bit            last;
  } frag_t;

  frag_t exp_q[$];

  always #5 clk = ~clk;

  width_serializer #(.IWIDTH(IW), .OWIDTH(OW), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_last(out_last_l), .out_idx(out_idx_l)
`ifdef WIDTH_SERIALIZER_KEEP_EN
    , .in_frags(in_frags)
`endif
  );

  width_serializer #(.IWIDTH(IW), .OWIDTH(OW), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_last(out_last_m), .out_idx(out_idx_m)
`ifdef WIDTH_SERIALIZER_KEEP_EN
    , .in_frags(in_frags)
`endif
  );

  // Reference: each accepted word expands into a list of pending fragments; the head is the output.
  always @(posedge clk or posedge reset) begin : model
    bit    rdy;
    int    n;
    frag_t f;
    if (reset) begin
      exp_q.delete();
    end else begin
      rdy = (exp_q.size() == 0) || (exp_q[0].last && out_ready);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) begin
        n = AMT;
`ifdef WIDTH_SERIALIZER_KEEP_EN
        if (in_frags != 0 && int'(in_frags) <= AMT) n = int'(in_frags);
`endif
        for (int k = 0; k < n; k++) begin
          f.dl   = OW'(in_data >> (OW * k));
          f.dm   = OW'(in_data >> (OW * (AMT - 1 - k)));
          f.idx  = k;
          f.last = (k == n - 1);
          exp_q.push_back(f);
        end
      end
    end
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
`ifdef WIDTH_SERIALIZER_KEEP_EN
    in_frags  = '0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", out_valid_l, out_valid_m); end
    checks++; if (out_last_l !== 1'b0 || out_last_m !== 1'b0) begin errors++; $display("FAIL reset_last got %b/%b want 0", out_last_l, out_last_m); end
    checks++; if (out_idx_l !== '0 || out_idx_m !== '0) begin errors++; $display("FAIL reset_idx got %0d/%0d want 0", out_idx_l, out_idx_m); end
    checks++; if (out_data_l !== '0 || out_data_m !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 00", out_data_l, out_data_m); end
    checks++; if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b/%b want 1", in_ready_l, in_ready_m); end
    reset = 1'b0;
  endtask

  task automatic test_known_word();
    logic [OW-1:0] el[4];
    el[0] = 8'hAA; el[1] = 8'hBB; el[2] = 8'hCC; el[3] = 8'hDD;
    drain();
    in_data  = 32'hDDCCBBAA;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (out_valid_l !== 1'b1) begin errors++; $display("FAIL known_valid[%0d] got %b want 1", k, out_valid_l); end
      checks++; if (out_data_l !== el[k]) begin errors++; $display("FAIL known_lsb_data[%0d] got %h want %h", k, out_data_l, el[k]); end
      checks++; if (out_data_m !== el[3-k]) begin errors++; $display("FAIL known_msb_data[%0d] got %h want %h", k, out_data_m, el[3-k]); end
      checks++; if (out_idx_l !== CW'(k) || out_idx_m !== CW'(k)) begin errors++; $display("FAIL known_idx[%0d] got %0d/%0d want %0d", k, out_idx_l, out_idx_m, k); end
      checks++; if (out_last_l !== (k == 3) || out_last_m !== (k == 3)) begin errors++; $display("FAIL known_last[%0d] got %b/%b want %b", k, out_last_l, out_last_m, k == 3); end
    end
    @(negedge clk);
    checks++; if (out_valid_l !== 1'b0) begin errors++; $display("FAIL known_idle got %b want 0", out_valid_l); end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] wa, wb, w;
    logic [OW-1:0] ew;
    wa = $urandom();
    wb = $urandom();
    drain();
    in_data  = wa;
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_l !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b want 1", in_ready_l); end
    @(posedge clk); #1;
    in_data = wb;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w  = (k < 4) ? wa : wb;
      ew = w[OW*(k%4) +: OW];
      checks++; if (out_valid_l !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", k, out_valid_l); end
      checks++; if (out_data_l !== ew) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, out_data_l, ew); end
      checks++; if (out_idx_l !== CW'(k % 4)) begin errors++; $display("FAIL b2b_idx[%0d] got %0d want %0d", k, out_idx_l, k % 4); end
      checks++; if (in_ready_l !== ((k % 4) == 3)) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want %b", k, in_ready_l, (k % 4) == 3); end
      if (k == 3) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (out_valid_l !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", out_valid_l); end
  endtask

  task automatic test_stall();
    logic [IW-1:0] w;
    logic [OW-1:0] ew;
    int k;
    int c;
    w = $urandom();
    drain();
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    k         = 0;
    c         = 0;
    out_ready = 1'b1;
    while (1) begin
      @(negedge clk);
      ew = w[OW*k +: OW];
      checks++; if (out_valid_l !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", c, out_valid_l); end
      checks++; if (out_data_l !== ew) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", c, out_data_l, ew); end
      checks++; if (out_idx_l !== CW'(k)) begin errors++; $display("FAIL stall_idx[%0d] got %0d want %0d", c, out_idx_l, k); end
      checks++; if (out_last_l !== (k == 3)) begin errors++; $display("FAIL stall_last[%0d] got %b want %b", c, out_last_l, k == 3); end
      if (out_ready) k++;
      if (k == 4) break;
      @(posedge clk); #1;
      c++;
      if (c > 20) begin
        errors++;
        $display("FAIL stall_timeout got %0d fragments want 4", k);
        break;
      end
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid_l !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", out_valid_l); end
  endtask

  task automatic test_reset_mid_word();
    drain();
    in_data  = $urandom();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_idx_l !== 2'd2) begin errors++; $display("FAIL midrst_pre_idx got %0d want 2", out_idx_l); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b/%b want 0", out_valid_l, out_valid_m); end
    checks++; if (out_idx_l !== '0 || out_last_l !== 1'b0) begin errors++; $display("FAIL midrst_idx_last got %0d/%b want 0/0", out_idx_l, out_last_l); end
    checks++; if (out_data_l !== '0 || out_data_m !== '0) begin errors++; $display("FAIL midrst_data got %h/%h want 00", out_data_l, out_data_m); end
    checks++; if (in_ready_l !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready_l); end
    @(negedge clk);
    reset   = 1'b0;
    in_data = 32'h44332211;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_l !== 1'b1) begin errors++; $display("FAIL midrst_next_valid got %b want 1", out_valid_l); end
    checks++; if (out_data_l !== 8'h11 || out_data_m !== 8'h44) begin errors++; $display("FAIL midrst_next_data got %h/%h want 11/44", out_data_l, out_data_m); end
    checks++; if (out_idx_l !== '0) begin errors++; $display("FAIL midrst_next_idx got %0d want 0", out_idx_l); end
  endtask

`ifdef WIDTH_SERIALIZER_KEEP_EN
  task automatic test_keep();
    drain();
    in_frags = 3'd2;
    in_data  = 32'hDDCCBBAA;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_frags = 3'd0;
    in_data  = 32'h44332211;
    @(negedge clk);
    checks++; if (out_data_l !== 8'hAA || out_last_l !== 1'b0) begin errors++; $display("FAIL keep_f0 got %h/%b want aa/0", out_data_l, out_last_l); end
    @(negedge clk);
    checks++; if (out_data_l !== 8'hBB || out_last_l !== 1'b1) begin errors++; $display("FAIL keep_f1 got %h/%b want bb/1", out_data_l, out_last_l); end
    checks++; if (in_ready_l !== 1'b1) begin errors++; $display("FAIL keep_in_ready got %b want 1", in_ready_l); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_data_l !== 8'h11 || out_idx_l !== '0) begin errors++; $display("FAIL keep_next got %h/%0d want 11/0", out_data_l, out_idx_l); end
  endtask
`endif

  task automatic test_random_stream();
    bit acc;
    bit exp_v;
    bit exp_r;
    drain();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_v = (exp_q.size() != 0);
      exp_r = !exp_v || (exp_q[0].last && out_ready);
      checks++; if (out_valid_l !== exp_v || out_valid_m !== exp_v) begin errors++; $display("FAIL rnd_valid[%0d] got %b/%b want %b", c, out_valid_l, out_valid_m, exp_v); end
      checks++; if (in_ready_l !== exp_r || in_ready_m !== exp_r) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b/%b want %b", c, in_ready_l, in_ready_m, exp_r); end
      if (exp_v) begin
        checks++; if (out_data_l !== exp_q[0].dl) begin errors++; $display("FAIL rnd_lsb_data[%0d] got %h want %h", c, out_data_l, exp_q[0].dl); end
        checks++; if (out_data_m !== exp_q[0].dm) begin errors++; $display("FAIL rnd_msb_data[%0d] got %h want %h", c, out_data_m, exp_q[0].dm); end
        checks++; if (out_idx_l !== CW'(exp_q[0].idx) || out_idx_m !== CW'(exp_q[0].idx)) begin errors++; $display("FAIL rnd_idx[%0d] got %0d/%0d want %0d", c, out_idx_l, out_idx_m, exp_q[0].idx); end
        checks++; if (out_last_l !== exp_q[0].last || out_last_m !== exp_q[0].last) begin errors++; $display("FAIL rnd_last[%0d] got %b/%b want %b", c, out_last_l, out_last_m, exp_q[0].last); end
      end
      acc = in_valid && in_ready_l;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom();
`ifdef WIDTH_SERIALIZER_KEEP_EN
        in_frags = 3'($urandom_range(0, AMT));
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_known_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
`ifdef WIDTH_SERIALIZER_KEEP_EN
    test_keep();
`endif
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
